reg_file: RTL and testbench

//   Integer register file for the LEGv8 datapath: NUM_REGS x REG_WIDTH storage.
//   - Two combinational read ports, one clocked write port.
//   - Highest-index register (X31/XZR) always reads zero.
//   - Feeds ALU operands in decode and takes the write-back result.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/reg_word.sv | 21 ++
 rtl/reg_file.sv | 47 ++++
 tb/tb_reg_file.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 integer register file.
// The top module takes its parameter defaults from here.
package regfile_pkg;

    localparam int DEF_REG_WIDTH = 64;
    localparam int DEF_NUM_REGS  = 32;

    // The highest index is XZR.
    localparam int ZERO_REG = DEF_NUM_REGS - 1;

    typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;

endpackage

// File: rtl/reg_word.sv
// One architectural register: a WIDTH-bit word with write enable.
// The reset is asynchronous and active-high.
module reg_word #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg_file.sv
// LEGv8 register file: two combinational read ports and one clocked write port.
// The highest-index register (XZR) has no storage and always reads zero.
module reg_file
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int NUM_REGS  = DEF_NUM_REGS,
    localparam int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [IDX_W-1:0]     WriteRegister,
    input  logic [REG_WIDTH-1:0] WriteData,
    input  logic [IDX_W-1:0]     ReadRegister1,
    input  logic [IDX_W-1:0]     ReadRegister2,
    output logic [REG_WIDTH-1:0] ReadData1,
    output logic [REG_WIDTH-1:0] ReadData2
);

    localparam int ZERO_SLOT = NUM_REGS - 1;

    logic [NUM_REGS-2:0]  wr_en;
    logic [REG_WIDTH-1:0] words [NUM_REGS];

    // XZR is the mux input driven by a constant; it has no storage and no enable.
    assign words[ZERO_SLOT] = '0;

    for (genvar i = 0; i < NUM_REGS - 1; i++) begin : g_reg
        assign wr_en[i] = RegWrite && (WriteRegister == IDX_W'(i));

        reg_word #(
            .WIDTH(REG_WIDTH)
        ) u_word (
            .clk  (clk),
            .reset(reset),
            .we   (wr_en[i]),
            .d    (WriteData),
            .q    (words[i])
        );
    end

    // Every index encoding is a valid register, so the muxes need no range check.
    assign ReadData1 = words[ReadRegister1];
    assign ReadData2 = words[ReadRegister2];

endmodule

// File: tb/tb_reg_file.sv
// Randomized scoreboard bench for reg_file.
// It checks the design against an array model of the architectural registers.
module tb_reg_file;
    import regfile_pkg::*;

    localparam int W = 64;
    localparam int N = 32;

    logic         clk;
    logic         reset;
    logic         RegWrite;
    reg_idx_t     WriteRegister;
    logic [W-1:0] WriteData;
    reg_idx_t     ReadRegister1;
    reg_idx_t     ReadRegister2;
    logic [W-1:0] ReadData1;
    logic [W-1:0] ReadData2;

    reg_file dut (
        .clk          (clk),
        .reset        (reset),
        .RegWrite     (RegWrite),
        .WriteRegister(WriteRegister),
        .WriteData    (WriteData),
        .ReadRegister1(ReadRegister1),
        .ReadRegister2(ReadRegister2),
        .ReadData1    (ReadData1),
        .ReadData2    (ReadData2)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // Reference model and scoreboard.
    logic [W-1:0]   model [N];
    logic [2*W-1:0] exp_q [$];
    string          name_q [$];
    event           rd_evt;
    int             vectors = 0;
    int             errors  = 0;

    function automatic logic [W-1:0] model_read(input int idx);
        return (idx == N - 1) ? '0 : model[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) model[i] = '0;
    endtask

    // Driver tasks.
    task automatic do_read(input int a, input int b, input string nm);
        ReadRegister1 = reg_idx_t'(a);
        ReadRegister2 = reg_idx_t'(b);
        exp_q.push_back({model_read(a), model_read(b)});
        name_q.push_back(nm);
        -> rd_evt;
        #2;
    endtask

    task automatic do_write(input logic we, input int idx, input logic [W-1:0] data);
        @(negedge clk);
        RegWrite      = we;
        WriteRegister = reg_idx_t'(idx);
        WriteData     = data;
        @(posedge clk);
        if (we && !reset && idx != N - 1) model[idx] = data;
        #1;
    endtask

    // Monitor: samples the read ports 1 time unit after each read request.
    initial begin
        logic [2*W-1:0] e;
        string          nm;
        forever begin
            @(rd_evt);
            #1;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: actual=empty required=entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                vectors++;
                if (ReadData1 !== e[2*W-1:W]) begin
                    errors++;
                    $display("FAIL %s rd1[%0d]: actual=%h required=%h", nm, ReadRegister1, ReadData1, e[2*W-1:W]);
                end
                vectors++;
                if (ReadData2 !== e[W-1:0]) begin
                    errors++;
                    $display("FAIL %s rd2[%0d]: actual=%h required=%h", nm, ReadRegister2, ReadData2, e[W-1:0]);
                end
            end
        end
    end

    initial begin
        reset         = 1'b1;
        RegWrite      = 1'b0;
        WriteRegister = '0;
        WriteData     = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        model_clear();

        // Reset clears every register.
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < N; i++) do_read(i, N - 1 - i, "reset_clear");

        // Fill each register with its own index.
        for (int i = 0; i < N; i++) do_write(1'b1, i, W'(i));
        do_write(1'b0, 0, '0);
        for (int i = 0; i < N; i++) do_read(i, N - 1 - i, "fill");

        // XZR ignores writes.
        do_write(1'b1, N - 1, 64'hA0);
        do_write(1'b0, 0, '0);
        do_read(N - 1, N - 1, "zero_reg");

        // With RegWrite low, writes of a second pattern must not land.
        for (int i = 0; i < N; i++) do_write(1'b1, i, W'(i) * 64'h0000010204080001);
        for (int i = 0; i < N; i++) do_write(1'b0, i, W'(i) * 64'h0000000000000101);
        for (int i = 0; i < N; i++) do_read(i, (i + 7) % N, "enable_gating");

        // Same-cycle read/write: the old value is seen until the edge.
        @(negedge clk);
        RegWrite      = 1'b1;
        WriteRegister = reg_idx_t'(5);
        WriteData     = 64'hDEAD;
        do_read(5, 5, "same_cycle_before");
        @(posedge clk);
        model[5] = 64'hDEAD;
        #1;
        do_read(5, 6, "same_cycle_after");
        @(negedge clk);
        RegWrite = 1'b0;

        // Asynchronous reset pulse between edges; a write during reset must not land.
        #1;
        reset = 1'b1;
        model_clear();
        #1;
        for (int i = 0; i < N; i += 3) do_read(i, N - 1 - i, "async_reset_held");
        do_write(1'b1, 9, 64'h1234_5678_9ABC_DEF0);
        @(negedge clk);
        reset    = 1'b0;
        RegWrite = 1'b0;
        for (int i = 0; i < N; i++) do_read(i, N - 1 - i, "async_reset_after");

        // Random writes and reads.
        for (int k = 0; k < 300; k++) begin
            do_write($urandom_range(0, 3) != 0, int'($urandom_range(0, N - 1)),
                     {$urandom, $urandom});
            do_read(int'($urandom_range(0, N - 1)), int'($urandom_range(0, N - 1)), "random");
        end

        #10;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
